keypad_num_entry: RTL and testbench

Scans a 4x4 matrix keypad, debounces key presses, and builds an 11-bit decimal value from typed digits. Its output `num` feeds the 4-digit FND display driver's `num` input directly, so keypad entry is the input-side counterpart to the scanned display output. It sits beside the ADC/display path and supplies operator-entered values such as thresholds and setpoints.

---
 rtl/keypad_num_entry.sv | 246 ++++++++++++++++++++++++
 tb/tb_keypad_num_entry.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/keypad_num_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_num_entry: 4x4 keypad scanner and debouncer that builds an 11-bit |
// | decimal value. Optional macro KEYPAD_COMMIT_EN adds a pending register.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module keypad_num_entry #(
  parameter int SCAN_DIV   = 135000,
  parameter int DEB_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  output logic [10:0] num,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        err
);

  localparam int C_SW = $clog2(SCAN_DIV);
  localparam int C_CW = $clog2(DEB_FRAMES + 1);
  localparam logic [C_SW-1:0] C_SLOT_LAST = C_SW'(SCAN_DIV - 1);
  localparam logic [C_CW-1:0] C_DEB       = C_CW'(DEB_FRAMES);

  localparam logic [1:0] C_IDLE    = 2'd0;
  localparam logic [1:0] C_PRESS   = 2'd1;
  localparam logic [1:0] C_HELD    = 2'd2;
  localparam logic [1:0] C_RELEASE = 2'd3;

  logic [3:0]      row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [C_SW-1:0] slot_q, slot_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      hits_q, hits_d;
  logic [3:0]      hcode_q, hcode_d;
  logic [1:0]      state_q, state_d;
  logic [C_CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      cand_q, cand_d;
  logic [10:0]     num_q, num_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            err_q, err_d;
`ifdef KEYPAD_COMMIT_EN
  logic [10:0]     pending_q, pending_d;
`endif

  logic            slot_last, frame_end, frame_key, accept;
  logic [2:0]      col_hits, hit_sum;
  logic [3:0]      col_code, frame_code;
  logic [1:0]      frame_hits;
  logic [10:0]     tgt, tgt_next;
  logic [14:0]     digit_sum;

  function automatic logic [3:0] code_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;   4'h1: code = 4'd2;  4'h2: code = 4'd3;  4'h3: code = 4'd10;
      4'h4: code = 4'd4;   4'h5: code = 4'd5;  4'h6: code = 4'd6;  4'h7: code = 4'd11;
      4'h8: code = 4'd7;   4'h9: code = 4'd8;  4'hA: code = 4'd9;  4'hB: code = 4'd12;
      4'hC: code = 4'd14;  4'hD: code = 4'd0;  4'hE: code = 4'd15; default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Scan timing plus per-frame hit accumulation (hits saturates at 2 = MULTI).
  always_comb begin
    row_s1_d  = key_row;
    row_s2_d  = row_s1_q;
    slot_last = (slot_q == C_SLOT_LAST);
    frame_end = slot_last && (col_q == 2'd3);
    slot_d    = slot_last ? '0 : slot_q + 1'b1;
    col_d     = slot_last ? col_q + 2'd1 : col_q;
    col_hits  = 3'd0;
    col_code  = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = code_map(2'(r), col_q);
      end
    end
    hit_sum    = {1'b0, hits_q} + col_hits;
    frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (hits_q != 2'd0) ? hcode_q : col_code;
    hits_d     = hits_q;
    hcode_d    = hcode_q;
    if (slot_last) begin
      hits_d  = frame_end ? 2'd0 : frame_hits;
      hcode_d = frame_end ? 4'd0 : frame_code;
    end
  end

  assign key_col = ~(4'b0001 << col_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      slot_q   <= '0;
      col_q    <= 2'd0;
      hits_q   <= 2'd0;
      hcode_q  <= 4'd0;
    end else begin
      row_s1_q <= row_s1_d;
      row_s2_q <= row_s2_d;
      slot_q   <= slot_d;
      col_q    <= col_d;
      hits_q   <= hits_d;
      hcode_q  <= hcode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    frame_key = (frame_hits == 2'd1);
    cnt_inc   = cnt_q + 1'b1;
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    accept    = 1'b0;
    if (frame_end) begin
      case (state_q)
        C_IDLE: begin
          if (frame_key) begin
            cand_d = frame_code;
            if (DEB_FRAMES <= 1) begin
              accept  = 1'b1;
              state_d = C_HELD;
              cnt_d   = '0;
            end else begin
              state_d = C_PRESS;
              cnt_d   = C_CW'(1);
            end
          end
        end
        C_PRESS: begin
          if (!frame_key) begin
            state_d = C_IDLE;
            cnt_d   = '0;
          end else if (frame_code != cand_q) begin
            cand_d = frame_code;
            cnt_d  = C_CW'(1);
          end else if (cnt_inc >= C_DEB) begin
            accept  = 1'b1;
            state_d = C_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        C_HELD: begin
          if (frame_hits == 2'd0) begin
            state_d = (DEB_FRAMES <= 1) ? C_IDLE : C_RELEASE;
            cnt_d   = (DEB_FRAMES <= 1) ? '0 : C_CW'(1);
          end
        end
        default: begin
          if (frame_hits != 2'd0) begin
            state_d = C_HELD;
            cnt_d   = '0;
          end else if (cnt_inc >= C_DEB) begin
            state_d = C_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  // Accept actions; digits, A and B edit whichever register the build targets.
  always_comb begin
    key_valid_d = 1'b0;
    err_d       = 1'b0;
    key_code_d  = key_code_q;
    num_d       = num_q;
`ifdef KEYPAD_COMMIT_EN
    pending_d   = pending_q;
    tgt         = pending_q;
`else
    tgt         = num_q;
`endif
    tgt_next  = tgt;
    digit_sum = 15'(tgt) * 15'd10 + 15'(frame_code);
    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = frame_code;
      if (frame_code <= 4'd9) begin
        if (digit_sum <= 15'd2047) tgt_next = digit_sum[10:0];
        else                       err_d    = 1'b1;
      end else if (frame_code == 4'd10) begin
        tgt_next = 11'd0;
      end else if (frame_code == 4'd11) begin
        tgt_next = tgt / 11'd10;
      end
    end
`ifdef KEYPAD_COMMIT_EN
    pending_d = tgt_next;
    if (accept && frame_code == 4'd15) begin
      num_d     = pending_q;
      pending_d = 11'd0;
    end
    if (accept && frame_code == 4'd14) pending_d = 11'd0;
`else
    num_d = tgt_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q       <= 11'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      err_q       <= 1'b0;
`ifdef KEYPAD_COMMIT_EN
      pending_q   <= 11'd0;
`endif
    end else begin
      num_q       <= num_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      err_q       <= err_d;
`ifdef KEYPAD_COMMIT_EN
      pending_q   <= pending_d;
`endif
    end
  end

  assign num       = num_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_num_entry.sv
`default_nettype none
// Testbench for keypad_num_entry: a virtual keypad drives the rows and an
// arithmetic model of typed entries predicts num, key_code and pulse counts.
module tb_keypad_num_entry;
  localparam int SCAN_DIV   = 4;
  localparam int DEB_FRAMES = 2;
  localparam int FRAME      = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [10:0] num;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        err;

  logic [15:0] held = '0;
  int checks = 0, errors = 0;
  int vcnt = 0, ecnt = 0;
  int m_num = 0, m_pend = 0, m_code = 0, m_valid = 0, m_err = 0;
  int code_at[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  always #5 clk = ~clk;

  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  keypad_num_entry #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .num(num), .key_valid(key_valid), .key_code(key_code), .err(err)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) vcnt++;
      if (err) ecnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":num"},   {21'd0, num},     32'(m_num));
    check({tag, ":code"},  {28'd0, key_code}, 32'(m_code));
    check({tag, ":valid"}, 32'(vcnt),          32'(m_valid));
    check({tag, ":err"},   32'(ecnt),          32'(m_err));
  endtask

  function automatic int pos_of(input int code);
    for (int i = 0; i < 16; i++) if (code_at[i] == code) return i;
    return 0;
  endfunction

  function automatic void model_key(input int code);
    int t;
`ifdef KEYPAD_COMMIT_EN
    t = m_pend;
`else
    t = m_num;
`endif
    m_code = code;
    m_valid++;
    if (code <= 9) begin
      if (t * 10 + code <= 2047) t = t * 10 + code;
      else m_err++;
    end else if (code == 10) t = 0;
    else if (code == 11) t = t / 10;
`ifdef KEYPAD_COMMIT_EN
    m_pend = t;
    if (code == 15) begin
      m_num  = m_pend;
      m_pend = 0;
    end
    if (code == 14) m_pend = 0;
`else
    m_num = t;
`endif
  endfunction

  task automatic press(input int code, input int hold_f, input int rel_f, input bit accepted);
    held[pos_of(code)] = 1'b1;
    cycles(hold_f * FRAME);
    held = '0;
    cycles(rel_f * FRAME);
    if (accepted) model_key(code);
    check_all($sformatf("key%0d", code));
  endtask

  initial begin
    int k, h, r;
    rst = 1'b1;
    cycles(5);
    check("rst_col",   {28'd0, key_col}, 32'hE);
    check("rst_num",   {21'd0, num},     32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_code",  {28'd0, key_code}, 32'd0);
    check("rst_err",   {31'd0, err},     32'd0);
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("col_%0d", i), {28'd0, key_col}, 32'(4'hF & ~(4'h1 << (i / SCAN_DIV))));
      cycles(1);
    end

    // Entry, overflow, backspace and clear.
    press(1, 4, 4, 1);
    press(2, 4, 4, 1);
    press(5, 4, 4, 1);
    press(10, 4, 4, 1);
    press(2, 4, 4, 1);
    press(0, 4, 4, 1);
    press(4, 4, 4, 1);
    press(8, 4, 4, 1);
    press(1, 4, 4, 1);
    press(11, 4, 4, 1);
    press(10, 4, 4, 1);

    // One-frame press, long hold, and two keys at once.
    press(3, 1, 4, 0);
    press(5, 20, 4, 1);
    held[pos_of(5)] = 1'b1;
    held[pos_of(6)] = 1'b1;
    cycles(6 * FRAME);
    held = '0;
    cycles(4 * FRAME);
    check_all("multi");

    // Commit sequence (no-op keys in the default build).
    press(4, 4, 4, 1);
    press(2, 4, 4, 1);
    press(15, 4, 4, 1);
    press(7, 4, 4, 1);
    press(14, 4, 4, 1);
    press(15, 4, 4, 1);

    // Reset in the middle of debouncing a press.
    held[pos_of(7)] = 1'b1;
    cycles(FRAME + FRAME / 2);
    rst  = 1'b1;
    held = '0;
    cycles(3);
    rst    = 1'b0;
    m_num  = 0;
    m_pend = 0;
    m_code = 0;
    cycles(4 * FRAME);
    check_all("mid_rst");

    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 15);
      h = $urandom_range(4, 6);
      r = $urandom_range(4, 6);
      cycles($urandom_range(0, FRAME - 1));
      press(k, h, r, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
